i2c_bus_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares a single I2C master engine between `NREQ` local requesters. Each requester posts a single-byte read or write to a 7-bit I2C slave address (the `i2c_Slave` memory model in the bench). The block grants one requester, launches the transaction on the master's command port, and supervises it with a timeout. It then returns the read data and status to the granted requester. It sits between the system-side clients and the I2C master, in the same `clk` domain.

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_bus_arbiter_rr_pick.sv | 37 +++
 rtl/i2c_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and codes for the I2C bus arbiter: FSM states, response status, command payload.
package i2c_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } arb_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_NACK    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam logic OP_READ  = 1'b1;
    localparam logic OP_WRITE = 1'b0;

    // Command latched at grant time and presented to the master until the next grant.
    typedef struct packed {
        logic              op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } i2c_cmd_t;

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, searching cyclically.
module rr_pick #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [IW:0]   pos;
    logic [IW-1:0] slot;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        pos   = '0;
        slot  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(NREQ)) begin
                pos = pos - (IW+1)'(NREQ);
            end
            slot = pos[IW-1:0];
            if (!found && req[slot]) begin
                found     = 1'b1;
                gnt[slot] = 1'b1;
                idx       = slot;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter that shares one I2C master engine between NREQ requesters,
// issuing one transaction at a time and supervising it with a timeout.
module i2c_bus_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         req_op,
    input  logic [NREQ*7-1:0]       req_addr,
    input  logic [NREQ*8-1:0]       req_wdata,
    output logic [NREQ-1:0]         gnt,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [7:0]              rsp_rdata,
    output logic [1:0]              rsp_err,
    output logic                    m_newd,
    output logic                    m_op,
    output logic [6:0]              m_addr,
    output logic [7:0]              m_din,
    input  logic                    m_busy,
    input  logic                    m_done,
    input  logic [7:0]              m_dout,
    input  logic                    m_ack_err
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    arb_state_t        state, state_d;
    logic [IW-1:0]     ptr, ptr_d;
    logic [IW-1:0]     gidx, gidx_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [NREQ-1:0]   gnt_d;
    i2c_cmd_t          cmd, cmd_d;
    logic              newd_d;
    logic              rsp_valid_d;
    logic [IW-1:0]     rsp_id_d;
    logic [7:0]        rsp_rdata_d;
    logic [1:0]        rsp_err_d;
    logic              expire;

    logic [NREQ-1:0]   pick_gnt;
    logic [IW-1:0]     pick_idx;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // State and output registers; reset clears every output immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gidx      <= '0;
            cnt       <= '0;
            gnt       <= '0;
            cmd       <= '0;
            m_newd    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= ERR_NONE;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            gidx      <= gidx_d;
            cnt       <= cnt_d;
            gnt       <= gnt_d;
            cmd       <= cmd_d;
            m_newd    <= newd_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        gidx_d      = gidx;
        cnt_d       = cnt;
        gnt_d       = gnt;
        cmd_d       = cmd;
        newd_d      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        expire      = (cnt == CW'(TIMEOUT - 1));

        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_d       = pick_gnt;
                    gidx_d      = pick_idx;
                    cmd_d.op    = req_op[pick_idx];
                    cmd_d.addr  = req_addr[ADDR_W*pick_idx +: ADDR_W];
                    cmd_d.wdata = req_wdata[DATA_W*pick_idx +: DATA_W];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                newd_d  = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY, WAIT_DONE: begin
                if (cnt != '1) begin
                    cnt_d = cnt + CW'(1);
                end
                // A completion in the expiry cycle still counts as success.
                if (m_done) begin
                    rsp_rdata_d = (cmd.op == OP_READ) ? m_dout : 8'h00;
                    rsp_err_d   = m_ack_err ? ERR_NACK : ERR_NONE;
                    state_d     = RESP;
                end else if (expire) begin
                    rsp_rdata_d = 8'h00;
                    rsp_err_d   = ERR_TIMEOUT;
                    state_d     = RESP;
                end else if (state == WAIT_BUSY && m_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = gidx;
                gnt_d       = '0;
                ptr_d       = (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign m_op   = cmd.op;
    assign m_addr = cmd.addr;
    assign m_din  = cmd.wdata;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter with a behavioural I2C master/slave and a response scoreboard.
module tb_i2c_bus_arbiter;

    localparam int NREQ = 4;
    localparam int TO   = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req;
    logic [3:0]      req_op;
    logic [27:0]     req_addr;
    logic [31:0]     req_wdata;
    logic [3:0]      gnt;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [7:0]      rsp_rdata;
    logic [1:0]      rsp_err;
    logic            m_newd;
    logic            m_op;
    logic [6:0]      m_addr;
    logic [7:0]      m_din;
    logic            m_busy;
    logic            m_done;
    logic [7:0]      m_dout;
    logic            m_ack_err;

    typedef struct {
        logic [1:0] id;
        logic [7:0] rdata;
        logic [1:0] err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   gnt_log[$];
    logic [3:0] gnt_prev;
    int   total = 0;
    int   bad = 0;
    int   newd_cnt = 0;
    int   rsp_cnt = 0;
    int   mmode = 0;

    always #5 clk = ~clk;

    i2c_bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .m_newd    (m_newd),
        .m_op      (m_op),
        .m_addr    (m_addr),
        .m_din     (m_din),
        .m_busy    (m_busy),
        .m_done    (m_done),
        .m_dout    (m_dout),
        .m_ack_err (m_ack_err)
    );

    // i2c_Slave memory contents as seen through the master.
    function automatic logic [7:0] slave_byte(input logic [6:0] a);
        return (a < 7'd16) ? {1'b0, a} : ({1'b0, a} ^ 8'h5A);
    endfunction

    task automatic set_lane(input int i, input logic op, input logic [6:0] a, input logic [7:0] d);
        req_op[i]            = op;
        req_addr[7*i +: 7]   = a;
        req_wdata[8*i +: 8]  = d;
    endtask

    // Master engine: busy after the command, done three cycles later (mode 0 only).
    initial begin
        m_busy = 1'b0; m_done = 1'b0; m_dout = 8'h00; m_ack_err = 1'b0;
        forever begin
            @(negedge clk);
            if (m_newd && mmode == 0) begin
                m_busy = 1'b1;
                repeat (3) @(negedge clk);
                m_dout    = m_op ? slave_byte(m_addr) : 8'hEE;
                m_ack_err = (m_addr == 7'h7F);
                m_done    = 1'b1;
                @(negedge clk);
                m_done = 1'b0; m_busy = 1'b0; m_ack_err = 1'b0; m_dout = 8'h00;
            end
        end
    end

    // Monitor: grant one-hot, grant order log, response scoreboard.
    initial begin
        gnt_prev = '0;
        forever begin
            @(negedge clk);
            if (m_newd) newd_cnt++;
            total++;
            if ($countones(gnt) > 1) begin
                bad++;
                $display("FAIL gnt_onehot: gnt=%b, required at most one bit set", gnt);
            end
            if (gnt != 4'b0 && gnt_prev == 4'b0) begin
                for (int k = 0; k < NREQ; k++) if (gnt[k]) gnt_log.push_back(k);
            end
            gnt_prev = gnt;
            if (rsp_valid) begin
                rsp_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_rsp: id=%0d rdata=%h err=%0d, required no response", rsp_id, rsp_rdata, rsp_err);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({rsp_id, rsp_rdata, rsp_err} !== {mon_e.id, mon_e.rdata, mon_e.err}) begin
                        bad++;
                        $display("FAIL rsp: got id=%0d rdata=%h err=%0d, required id=%0d rdata=%h err=%0d",
                                 rsp_id, rsp_rdata, rsp_err, mon_e.id, mon_e.rdata, mon_e.err);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d responses pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '0; req_op = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({gnt, rsp_valid, rsp_id, rsp_rdata, rsp_err, m_newd} !== 17'b0) begin
            bad++;
            $display("FAIL reset_rsp: gnt=%b valid=%b id=%0d rdata=%h err=%0d newd=%b, required all 0",
                     gnt, rsp_valid, rsp_id, rsp_rdata, rsp_err, m_newd);
        end
        total++;
        if ({m_op, m_addr, m_din} !== 16'b0) begin
            bad++;
            $display("FAIL reset_cmd: op=%b addr=%h din=%h, required 0", m_op, m_addr, m_din);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (gnt !== 4'b0) begin
            bad++;
            $display("FAIL idle_no_req: gnt=%b, required 0000", gnt);
        end
    endtask

    task automatic test_round_robin();
        int seen, n0, r0;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NREQ; i++) set_lane(i, 1'b1, 7'(16 + i), 8'h00);
        for (int i = 0; i < 5; i++)
            exp_q.push_back('{id: 2'(exp_order[i]), rdata: slave_byte(7'(16 + exp_order[i])), err: 2'd0});
        gnt_log.delete();
        n0 = newd_cnt; r0 = rsp_cnt; seen = 0;
        req = 4'hF;
        for (int c = 0; c < 400 && seen < 5; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        req = 4'h0;
        wait_drain("rr", 50);
        total++;
        if (gnt_log.size() != 5) begin
            bad++;
            $display("FAIL rr_count: %0d grants, required 5", gnt_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (gnt_log[i] != exp_order[i]) begin
                    bad++;
                    $display("FAIL rr_order[%0d]: granted %0d, required %0d", i, gnt_log[i], exp_order[i]);
                end
            end
        end
        total++;
        if ((newd_cnt - n0) != 5 || (rsp_cnt - r0) != 5) begin
            bad++;
            $display("FAIL rr_newd_per_rsp: newd=%0d rsp=%0d, required 5 and 5", newd_cnt - n0, rsp_cnt - r0);
        end
    endtask

    task automatic test_single_read();
        set_lane(0, 1'b1, 7'h05, 8'h00);
        exp_q.push_back('{id: 2'd0, rdata: 8'h05, err: 2'd0});
        req = 4'b0001;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001 || m_newd !== 1'b0) begin
            bad++;
            $display("FAIL read_grant: gnt=%b newd=%b, required 0001 and 0", gnt, m_newd);
        end
        @(negedge clk);
        req = 4'b0000;
        total++;
        if (m_newd !== 1'b1 || m_op !== 1'b1 || m_addr !== 7'h05) begin
            bad++;
            $display("FAIL read_cmd: newd=%b op=%b addr=%h, required 1 1 05", m_newd, m_op, m_addr);
        end
        wait_drain("read", 50);
    endtask

    task automatic test_write_nack();
        logic stable;
        set_lane(2, 1'b0, 7'h7F, 8'hA5);
        exp_q.push_back('{id: 2'd2, rdata: 8'h00, err: 2'd1});
        req = 4'b0100;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0100) begin
            bad++;
            $display("FAIL nack_grant: gnt=%b, required 0100", gnt);
        end
        req = 4'b0000;
        set_lane(2, 1'b1, 7'h00, 8'h00);
        stable = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (m_din !== 8'hA5 || m_addr !== 7'h7F || m_op !== 1'b0) stable = 1'b0;
            if (rsp_valid) break;
        end
        total++;
        if (stable !== 1'b1) begin
            bad++;
            $display("FAIL nack_cmd_stable: din=%h addr=%h op=%b, required A5 7F 0 throughout", m_din, m_addr, m_op);
        end
        wait_drain("nack", 50);
    endtask

    task automatic test_timeout();
        int t, tval;
        logic got;
        mmode = 1;
        set_lane(3, 1'b1, 7'h22, 8'h00);
        set_lane(0, 1'b1, 7'h06, 8'h00);
        exp_q.push_back('{id: 2'd3, rdata: 8'h00, err: 2'd2});
        exp_q.push_back('{id: 2'd0, rdata: slave_byte(7'h06), err: 2'd0});
        t = -1; tval = -1; got = 1'b0;
        req = 4'b1001;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (t >= 0 && !got) t++;
            if (m_newd && t < 0) t = 0;
            if (t >= 0 && !got && rsp_err == 2'd2) begin
                got = 1'b1;
                tval = t;
            end
            if (rsp_valid) mmode = 0;
            if (gnt[0]) break;
        end
        total++;
        if (tval != 16) begin
            bad++;
            $display("FAIL timeout_latency: %0d cycles from newd to timeout, required 16", tval);
        end
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL timeout_next_grant: gnt=%b, required 0001", gnt);
        end
        req = 4'b0000;
        wait_drain("timeout", 60);
    endtask

    task automatic test_collision();
        mmode = 1;
        @(negedge clk);
        m_done = 1'b1; m_dout = 8'h77;
        @(negedge clk);
        m_done = 1'b0; m_dout = 8'h00;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || gnt !== 4'b0) begin
            bad++;
            $display("FAIL spurious_done: valid=%b gnt=%b, required 0 and 0000", rsp_valid, gnt);
        end
        set_lane(1, 1'b1, 7'h31, 8'h00);
        exp_q.push_back('{id: 2'd1, rdata: slave_byte(7'h31), err: 2'd0});
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        total++;
        if (m_newd !== 1'b1) begin
            bad++;
            $display("FAIL collide_newd: newd=%b, required 1", m_newd);
        end
        m_busy = 1'b1;
        repeat (TO - 1) @(negedge clk);
        m_dout = slave_byte(7'h31);
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0; m_busy = 1'b0; m_dout = 8'h00;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL rsp_latency: valid=%b one cycle after done, required 1", rsp_valid);
        end
        wait_drain("collide", 20);
        mmode = 0;
    endtask

    task automatic test_reset_mid();
        mmode = 1;
        for (int i = 0; i < NREQ; i++) set_lane(i, 1'b1, 7'(64 + i), 8'h00);
        req = 4'hF;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0100) begin
            bad++;
            $display("FAIL rstmid_grant: gnt=%b, required 0100", gnt);
        end
        @(negedge clk);
        m_busy = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_busy = 1'b0;
        #1;
        total++;
        if ({gnt, rsp_valid, m_newd, m_addr} !== 13'b0) begin
            bad++;
            $display("FAIL rstmid_outputs: gnt=%b valid=%b newd=%b addr=%h, required all 0", gnt, rsp_valid, m_newd, m_addr);
        end
        repeat (3) @(negedge clk);
        exp_q.push_back('{id: 2'd0, rdata: slave_byte(7'd64), err: 2'd0});
        mmode = 0;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL rstmid_regrant: gnt=%b, required 0001", gnt);
        end
        req = 4'b0000;
        wait_drain("rstmid", 50);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_read();
        test_write_nack();
        test_timeout();
        test_collision();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
